// File: rtl/wb_result_select_pipe.sv
// Writeback result selector: one-hot AND-OR mux, constant override, sub-word extension,
// 2-entry (main + skid) output stage. Define WBX_ONEHOT_CHK_EN to enable the sel one-hot check.
module wb_result_select_pipe #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 8,
  parameter int TAGW  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic [NSRC-1:0]       sel,
  input  logic [2:0]            zom,
  input  logic [1:0]            ext,
  input  logic [TAGW-1:0]       tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [TAGW-1:0]       out_tag,
  output logic                  out_sel_err
);

  logic [WIDTH-1:0] presel;
  logic [WIDTH-1:0] res_d;

  logic             main_valid;
  logic [WIDTH-1:0] main_result;
  logic [TAGW-1:0]  main_tag;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic [TAGW-1:0]  skid_tag;

  logic accept;
  logic drain;
  logic main_from_skid;
  logic main_from_in;
  logic skid_from_in;

  always_comb begin
    presel = '0;
    for (int i = 0; i < NSRC; i++) begin
      presel = presel | (src[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

  always_comb begin
    res_d = presel;
    if (zom[2]) begin
      res_d = '1;
    end else if (zom[1]) begin
      res_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (zom[0]) begin
      res_d = '0;
    end else begin
      case (ext)
        2'b01:   res_d = {{(WIDTH-8){presel[7]}}, presel[7:0]};
        2'b10:   res_d = {{(WIDTH-16){presel[15]}}, presel[15:0]};
        2'b11:   res_d = {{(WIDTH-16){1'b0}}, presel[15:0]};
        default: res_d = presel;
      endcase
    end
  end

  // skid_valid is a flop, so in_ready is registered; no accept can coincide with a skid->main move
  assign in_ready       = ~skid_valid;
  assign accept         = in_valid & in_ready;
  assign drain          = main_valid & out_ready;
  assign main_from_skid = drain & skid_valid;
  assign main_from_in   = accept & (~main_valid | drain);
  assign skid_from_in   = accept & main_valid & ~drain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid  <= 1'b0;
      main_result <= '0;
      main_tag    <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_tag    <= '0;
    end else begin
      if (main_from_skid) begin
        main_valid  <= 1'b1;
        main_result <= skid_result;
        main_tag    <= skid_tag;
        skid_valid  <= 1'b0;
      end else if (main_from_in) begin
        main_valid  <= 1'b1;
        main_result <= res_d;
        main_tag    <= tag;
      end else if (drain) begin
        main_valid  <= 1'b0;
      end
      if (skid_from_in) begin
        skid_valid  <= 1'b1;
        skid_result <= res_d;
        skid_tag    <= tag;
      end
    end
  end

  assign out_valid  = main_valid;
  assign out_result = main_result;
  assign out_tag    = main_tag;

`ifdef WBX_ONEHOT_CHK_EN
  localparam int CW = $clog2(NSRC + 1);

  logic [CW-1:0] sel_cnt;
  logic          sel_err_d;
  logic          main_err;
  logic          skid_err;

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel_cnt = sel_cnt + CW'(sel[i]);
    end
    sel_err_d = (sel_cnt != CW'(1)) && (zom == 3'b000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (main_from_skid) begin
        main_err <= skid_err;
      end else if (main_from_in) begin
        main_err <= sel_err_d;
      end
      if (skid_from_in) begin
        skid_err <= sel_err_d;
      end
    end
  end

  assign out_sel_err = main_err;
`else
  assign out_sel_err = 1'b0;
`endif

endmodule
